// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package if_id_queue_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side signals of the IF/ID queue.
// slave: the queue itself; master: whoever drives fetch words and the decode stall.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pcplus4;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pcplus4;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_instr, in_pc, in_pcplus4, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pcplus4, count
  );

  modport master (
    output in_valid, in_instr, in_pc, in_pcplus4, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pcplus4, count
  );

endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetch packets with
// first-word fall-through from storage. Full/empty come from the
// occupancy counter; pointers wrap naturally at DEPTH (power of two).
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_pkt_t       mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  logic             full, empty;
  logic             push, pop;
  fetch_pkt_t       wr_pkt, head;

  // Occupancy flags; in_ready depends on count only, so decode stalls
  // never reach fetch combinationally.
  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = q.in_valid & ~full & ~q.flush;
    pop   = ~empty & q.out_ready & ~q.flush;
  end

  // Next-state pointers and count; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer/count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_pkt.instr   = q.in_instr;
    wr_pkt.pc      = q.in_pc;
    wr_pkt.pcplus4 = q.in_pcplus4;
  end

  // Storage write; contents are never cleared, only masked by count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_pkt;
  end

  // Head presentation straight from storage; empty shows a NOP with zero PCs
  // so decode never sees stale or undefined data.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    q.in_ready    = ~full;
    q.out_valid   = ~empty;
    q.count       = count_q;
    q.out_instr   = empty ? NOP_INSTR : head.instr;
    q.out_pc      = empty ? '0        : head.pc;
    q.out_pcplus4 = empty ? '0        : head.pcplus4;
  end

endmodule
